// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared defaults and FSM state encoding for the VRAM arbiter
package vram_arb_pkg;

    localparam int ADDR_W_DEF   = 19;
    localparam int DATA_W_DEF   = 12;
    localparam int WB_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DATA  = 2'd3
    } state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: CPU-side request/ready bus of the VRAM arbiter
interface vram_arbiter_if #(
    parameter int ADDR_W = vram_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = vram_arb_pkg::DATA_W_DEF
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);

endinterface

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: posted-write buffer holding {address, pixel} entries in FIFO order
module vram_wr_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Occupancy gates requests so a full buffer never overwrites and an empty one never underflows
    always_comb begin
        full     = count_q == (AW+1)'(DEPTH);
        empty    = count_q == '0;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout     = mem_q[rd_ptr_q];
        count    = count_q;
    end

    // Pointers and occupancy; clearing them discards any buffered entries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between scanout (absolute priority) and a CPU with posted writes
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WB_DEPTH = WB_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    vram_arbiter_if.slave              cpu,
    input  logic                       vga_rdn,
    input  logic [ADDR_W-1:0]          vga_addr,
    output logic [ADDR_W-1:0]          vram_addr,
    output logic                       vram_we,
    output logic [DATA_W-1:0]          vram_din,
    input  logic [DATA_W-1:0]          vram_dout,
    output logic [$clog2(WB_DEPTH):0]  wb_count,
    output logic                       busy
);

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic [ADDR_W+DATA_W-1:0]   head;
    logic                       full, empty, wr_acc, drain;

    vram_wr_fifo #(.W(ADDR_W + DATA_W), .DEPTH(WB_DEPTH)) u_wr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_acc),
        .pop   (drain),
        .din   ({cpu.addr, cpu.wdata}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (wb_count)
    );

    // Port steering: scanout first, then draining posted writes, else park on the read address
    always_comb begin
        wr_acc    = rst && cpu.req && cpu.we && state_q == IDLE && !full;
        drain     = vga_rdn && !empty && state_q != RD_ISSUE && state_q != RD_DATA;
        cpu.ready = wr_acc || (cpu.req && state_q == RD_DATA);
        cpu.rdata = state_q == RD_DATA ? vram_dout : rdata_q;
        vram_addr = !vga_rdn ? vga_addr : drain ? head[ADDR_W+DATA_W-1:DATA_W] : rd_addr_q;
        vram_we   = drain;
        vram_din  = head[DATA_W-1:0];
        busy      = state_q != IDLE || !empty;
    end

    // Read sequencing: wait for the buffer to drain, issue when scanout is idle, retry if it steals the slot
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: if (cpu.req && !cpu.we) begin
                state_d   = RD_WAIT;
                rd_addr_d = cpu.addr;
            end
            RD_WAIT:  state_d = empty && vga_rdn ? RD_ISSUE : RD_WAIT;
            RD_ISSUE: state_d = vga_rdn ? RD_DATA : RD_WAIT;
            RD_DATA: begin
                rdata_d = vram_dout;
                state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // State and read-path registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized self-checking bench with a sequential-memory reference model
module tb_vram_arbiter;

    localparam int AW = 19;
    localparam int DW = 12;
    localparam int D  = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  vga_rdn = 1'b1;
    logic [AW-1:0]         vga_addr = '0;
    logic [AW-1:0]         vram_addr;
    logic                  vram_we;
    logic [DW-1:0]         vram_din;
    logic [DW-1:0]         vram_dout;
    logic [$clog2(D):0]    wb_count;
    logic                  busy;

    int n_chk = 0;
    int n_fail = 0;

    wr_t           exp_q [$];
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] vmem [logic [AW-1:0]];

    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WB_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu_if),
        .vga_rdn   (vga_rdn),
        .vga_addr  (vga_addr),
        .vram_addr (vram_addr),
        .vram_we   (vram_we),
        .vram_din  (vram_din),
        .vram_dout (vram_dout),
        .wb_count  (wb_count),
        .busy      (busy)
    );

    // Synchronous VRAM with one cycle read latency (read returns pre-write contents)
    always @(posedge clk) begin
        vram_dout <= vmem.exists(vram_addr) ? vmem[vram_addr] : '0;
        if (vram_we === 1'b1) vmem[vram_addr] = vram_din;
    end

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : '0;
    endfunction

    // Cycle monitor: scanout priority, FIFO retire order, occupancy and read data against the model
    always @(negedge clk) begin
        wr_t h;
        if (rst === 1'b1) begin
            n_chk++;
            if (int'(wb_count) !== exp_q.size()) begin
                n_fail++;
                $display("FAIL mon_wb_count: got %0d expected %0d", wb_count, exp_q.size());
            end
            n_chk++;
            if (cpu_if.ready === 1'b1 && cpu_if.req !== 1'b1) begin
                n_fail++;
                $display("FAIL mon_ready_without_req: ready=%b req=%b", cpu_if.ready, cpu_if.req);
            end
            if (vga_rdn === 1'b0) begin
                n_chk++;
                if (vram_addr !== vga_addr || vram_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mon_scanout: vram_addr=%h vram_we=%b expected addr %h we 0", vram_addr, vram_we, vga_addr);
                end
            end
            if (vram_we === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_spurious_write: addr=%h din=%h expected no write", vram_addr, vram_din);
                end else begin
                    h = exp_q.pop_front();
                    model_mem[h.a] = h.d;
                    if ({vram_addr, vram_din} !== h) begin
                        n_fail++;
                        $display("FAIL mon_write_order: got %h/%h expected %h/%h", vram_addr, vram_din, h.a, h.d);
                    end
                end
            end
            if (cpu_if.ready === 1'b1 && cpu_if.we === 1'b1) exp_q.push_back({cpu_if.addr, cpu_if.wdata});
            if (cpu_if.ready === 1'b1 && cpu_if.we === 1'b0) begin
                n_chk++;
                if (cpu_if.rdata !== mread(cpu_if.addr)) begin
                    n_fail++;
                    $display("FAIL mon_read_data: addr=%h got %h expected %h", cpu_if.addr, cpu_if.rdata, mread(cpu_if.addr));
                end
            end
        end
    end

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int budget, output int waited);
        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = a; cpu_if.wdata = d;
        waited = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cpu_if.ready === 1'b1) begin
                waited = i;
                break;
            end
            @(posedge clk); #1;
        end
        if (waited >= 0) begin
            @(posedge clk); #1;
        end
        cpu_if.req = 1'b0; cpu_if.we = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input int budget, output logic [DW-1:0] data, output int lat);
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = a;
        lat = -1;
        data = 'x;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cpu_if.ready === 1'b1) begin
                lat = i;
                data = cpu_if.rdata;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
        end
        cpu_if.req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; vga_rdn = 1'b1;
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_chk++;
        if (cpu_if.ready !== 1'b0 || wb_count !== 0 || busy !== 1'b0 || vram_we !== 1'b0 || cpu_if.rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b wb=%0d busy=%b we=%b rdata=%h expected 0/0/0/0/000",
                     cpu_if.ready, wb_count, busy, vram_we, cpu_if.rdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single_write();
        int w;
        vga_rdn = 1'b1;
        cpu_write(19'h00010, 12'h1A5, 5, w);
        n_chk++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL single_write_ready: waited %0d expected 0", w);
        end
        @(negedge clk);
        n_chk++;
        if (vram_we !== 1'b1 || vram_addr !== 19'h00010 || vram_din !== 12'h1A5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write_drain: we=%b addr=%h din=%h busy=%b expected 1/00010/1a5/1", vram_we, vram_addr, vram_din, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        wr_t exp_w [5];
        wr_t got [$];
        int w, acc_cyc;
        vga_rdn = 1'b0;
        vga_addr = AW'($urandom);
        for (int i = 0; i < 5; i++) exp_w[i] = {AW'(32'h200 + 32'(i) * 7), DW'($urandom)};
        for (int i = 0; i < 4; i++) begin
            cpu_write(exp_w[i].a, exp_w[i].d, 3, w);
            n_chk++;
            if (w !== 0) begin
                n_fail++;
                $display("FAIL full_fill_%0d: waited %0d expected 0", i, w);
            end
        end
        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = exp_w[4].a; cpu_if.wdata = exp_w[4].d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (cpu_if.ready !== 1'b0 || wb_count !== 4 || vram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL full_stall: ready=%b wb=%0d we=%b expected 0/4/0", cpu_if.ready, wb_count, vram_we);
            end
            @(posedge clk); #1;
        end
        vga_rdn = 1'b1;
        acc_cyc = -1;
        for (int c = 0; c < 12 && got.size() < 5; c++) begin
            @(negedge clk);
            if (vram_we === 1'b1) got.push_back({vram_addr, vram_din});
            if (cpu_if.req === 1'b1 && cpu_if.ready === 1'b1) acc_cyc = c;
            @(posedge clk); #1;
            if (acc_cyc == c) begin
                cpu_if.req = 1'b0; cpu_if.we = 1'b0;
            end
        end
        n_chk++;
        if (acc_cyc < 1) begin
            n_fail++;
            $display("FAIL full_fifth_accept: accept cycle %0d expected >=1", acc_cyc);
        end
        n_chk++;
        if (got.size() != 5) begin
            n_fail++;
            $display("FAIL full_drain_count: got %0d writes expected 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL full_drain_order_%0d: got %h expected %h", i, got[i], exp_w[i]);
            end
        end
        cpu_if.req = 1'b0; cpu_if.we = 1'b0;
    endtask

    task automatic test_raw();
        int w, seen;
        logic [DW-1:0] d;
        int wb_at;
        vga_rdn = 1'b0;
        cpu_write(19'h00100, 12'h3FF, 3, w);
        n_chk++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL raw_write: waited %0d expected 0", w);
        end
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 19'h00100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (cpu_if.ready !== 1'b0 || wb_count !== 1) begin
                n_fail++;
                $display("FAIL raw_hold: ready=%b wb=%0d expected 0/1", cpu_if.ready, wb_count);
            end
            @(posedge clk); #1;
        end
        vga_rdn = 1'b1;
        seen = 0; d = '0; wb_at = -1;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (cpu_if.ready === 1'b1) begin
                seen = 1; d = cpu_if.rdata; wb_at = int'(wb_count);
            end
            @(posedge clk); #1;
        end
        cpu_if.req = 1'b0;
        n_chk++;
        if (seen != 1 || d !== 12'h3FF || wb_at != 0) begin
            n_fail++;
            $display("FAIL raw_read: seen=%0d data=%h wb_at_ready=%0d expected 1/3ff/0", seen, d, wb_at);
        end
    endtask

    task automatic test_latency();
        logic [AW-1:0] a;
        logic [DW-1:0] d, r;
        int w, lat;
        vga_rdn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = AW'($urandom);
            d = DW'($urandom);
            cpu_write(a, d, 5, w);
            repeat (2) @(posedge clk);
            #1;
            cpu_read(a, 10, r, lat);
            n_chk++;
            if (lat != 3 || r !== d) begin
                n_fail++;
                $display("FAIL latency_%0d: lat=%0d data=%h expected 3/%h", k, lat, r, d);
            end
            @(negedge clk);
            n_chk++;
            if (cpu_if.ready !== 1'b0 || cpu_if.rdata !== d || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_hold_%0d: ready=%b rdata=%h busy=%b expected 0/%h/0", k, cpu_if.ready, cpu_if.rdata, busy, d);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_retry();
        logic [AW-1:0] a;
        logic [DW-1:0] d, r;
        int w, pulses, lat;
        vga_rdn = 1'b1;
        a = AW'($urandom);
        d = DW'($urandom);
        cpu_write(a, d, 5, w);
        repeat (2) @(posedge clk);
        #1;
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = a;
        pulses = 0; lat = -1; r = '0;
        for (int c = 0; c < 10; c++) begin
            vga_rdn = (c == 2) ? 1'b0 : 1'b1;
            vga_addr = AW'($urandom);
            @(negedge clk);
            if (cpu_if.ready === 1'b1) begin
                pulses++; lat = c; r = cpu_if.rdata;
            end
            @(posedge clk); #1;
            if (lat == c) cpu_if.req = 1'b0;
        end
        cpu_if.req = 1'b0;
        vga_rdn = 1'b1;
        n_chk++;
        if (pulses != 1 || lat != 5 || r !== d) begin
            n_fail++;
            $display("FAIL retry: pulses=%0d lat=%0d data=%h expected 1/5/%h", pulses, lat, r, d);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        vga_rdn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_write(AW'(32'h400 + 32'(i)), DW'($urandom), 3, w);
            n_chk++;
            if (w !== 0) begin
                n_fail++;
                $display("FAIL rstmid_fill_%0d: waited %0d expected 0", i, w);
            end
        end
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 19'h00400;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        n_chk++;
        if (cpu_if.ready !== 1'b0 || wb_count !== 0 || busy !== 1'b0 || vram_we !== 1'b0 || cpu_if.rdata !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: ready=%b wb=%0d busy=%b we=%b rdata=%h expected 0/0/0/0/000",
                     cpu_if.ready, wb_count, busy, vram_we, cpu_if.rdata);
        end
        vga_rdn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (vram_we !== 1'b0 || cpu_if.ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_held: we=%b ready=%b expected 0/0", vram_we, cpu_if.ready);
            end
        end
        @(posedge clk); #1;
        cpu_if.req = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (vram_we !== 1'b0 || wb_count !== 0 || busy !== 1'b0 || cpu_if.ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_after: we=%b wb=%0d busy=%b ready=%b expected 0/0/0/0", vram_we, wb_count, busy, cpu_if.ready);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [8];
        logic [DW-1:0] r;
        logic [AW-1:0] a;
        int w, lat;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    a = pool[$urandom_range(0, 7)];
                    if ($urandom_range(0, 2) != 0) begin
                        cpu_write(a, DW'($urandom), 100, w);
                        n_chk++;
                        if (w < 0) begin
                            n_fail++;
                            $display("FAIL random_write_%0d: timed out, expected acceptance", k);
                        end
                    end else begin
                        cpu_read(a, 200, r, lat);
                        n_chk++;
                        if (lat < 3 || r !== mread(a)) begin
                            n_fail++;
                            $display("FAIL random_read_%0d: lat=%0d data=%h expected >=3/%h", k, lat, r, mread(a));
                        end
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    vga_rdn = ($urandom_range(0, 9) < 5) ? 1'b0 : 1'b1;
                    vga_addr = AW'($urandom);
                    @(posedge clk); #1;
                end
            end
        join
        vga_rdn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_chk++;
        if (wb_count !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_final_idle: wb=%0d busy=%b expected 0/0", wb_count, busy);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_full();
        test_raw();
        test_latency();
        test_retry();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
